// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: the display fetch path has priority, and the
// host gets a bounded wait. Accepted requests are issued one cycle later, and
// read data is routed back to its owner through a fixed-latency return pipe.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_forced,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]   wait_cnt;
  logic               force_grant;
  logic               issue_host_p0;
  logic               issue_rd_p0;
  logic [MEM_LAT-1:0] ret_vld_p1;
  logic [MEM_LAT-1:0] ret_host_p1;
  logic               tail_vld;
  logic               tail_host;

  // Grant selection: a starved host wins, otherwise display, otherwise host.
  always_comb begin
    force_grant = 1'b0;
    disp_gnt    = 1'b0;
    host_ready  = 1'b0;
    if (Reset) begin
      force_grant = host_valid && (STARVE_MAX != 0) && (wait_cnt == WAIT_LIM);
      if (force_grant) begin
        host_ready = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else begin
        host_ready = host_valid;
      end
    end
  end

  // Count consecutive cycles the host has been kept waiting, saturating at the limit.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if (!host_valid || host_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // ---- stage p0: register the accepted access onto the RAM port ----
  // Issue register; address and write data hold when nothing is accepted.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      issue_host_p0 <= 1'b0;
      host_forced   <= 1'b0;
    end else begin
      mem_en        <= disp_gnt || host_ready;
      mem_we        <= host_ready && host_we;
      issue_host_p0 <= host_ready;
      host_forced   <= force_grant;
      if (host_ready) begin
        mem_addr <= host_addr;
        if (host_we) begin
          mem_wdata <= host_wdata;
        end
      end else if (disp_gnt) begin
        mem_addr <= disp_addr;
      end
    end
  end

  assign issue_rd_p0 = mem_en && !mem_we;

  // ---- stage p1: return pipe tracking {valid, owner} alongside the RAM latency ----
  // Shift register whose tail lines up with mem_rdata for the tracked read.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ret_vld_p1  <= '0;
      ret_host_p1 <= '0;
    end else begin
      ret_vld_p1[0]  <= issue_rd_p0;
      ret_host_p1[0] <= issue_host_p0;
      for (int i = 1; i < MEM_LAT; i++) begin
        ret_vld_p1[i]  <= ret_vld_p1[i-1];
        ret_host_p1[i] <= ret_host_p1[i-1];
      end
    end
  end

  assign tail_vld  = ret_vld_p1[MEM_LAT-1];
  assign tail_host = ret_host_p1[MEM_LAT-1];

  // ---- stage p2: capture read data into the owner's result register ----
  // Route the returning word to its owner; rdata holds between returns.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      disp_rvalid <= tail_vld && !tail_host;
      host_rvalid <= tail_vld && tail_host;
      if (tail_vld && !tail_host) begin
        disp_rdata <= mem_rdata;
      end
      if (tail_vld && tail_host) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: three instances with different latency/starvation
// settings share one stimulus stream, each with its own RAM model, and are
// checked every cycle against a transaction-level scoreboard.
module tb_vga_fb_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, dreq, hv, hwe;
  logic [AW-1:0] daddr, haddr;
  logic [DW-1:0] hwdata;

  logic          dg [NI], hr [NI], drv [NI], hrv [NI], hf [NI], men [NI], mwe [NI];
  logic [DW-1:0] drd [NI], hrd [NI], mwd [NI], mrd [NI];
  logic [AW-1:0] mad [NI];

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : 1;
  endfunction
  function automatic int sm_of(input int g);
    return (g == 0) ? 8 : (g == 1) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    localparam int SM  = (g == 0) ? 8 : (g == 1) ? 1 : 0;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
      .Clock(clk), .Reset(rst_n),
      .disp_req(dreq), .disp_addr(daddr), .disp_gnt(dg[g]),
      .disp_rdata(drd[g]), .disp_rvalid(drv[g]),
      .host_valid(hv), .host_we(hwe), .host_addr(haddr), .host_wdata(hwdata),
      .host_ready(hr[g]), .host_rdata(hrd[g]), .host_rvalid(hrv[g]),
      .host_forced(hf[g]),
      .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(mad[g]), .mem_wdata(mwd[g]),
      .mem_rdata(mrd[g])
    );

    // RAM model: unwritten words read back as their own address (stored XOR addr).
    bit [DW-1:0] ram [1<<AW];
    bit [DW-1:0] dly [LAT];
    always @(posedge clk) begin
      if (men[g] && mwe[g]) ram[mad[g]] <= mwd[g] ^ mad[g][DW-1:0];
      dly[0] <= ram[mad[g]] ^ mad[g][DW-1:0];
      for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
    end
    assign mrd[g] = dly[LAT-1];
  end

  // Scoreboard state
  bit   [DW-1:0] mm [NI][1<<AW];
  int            mwait [NI];
  logic          e_en [NI], e_we [NI], e_drv [NI], e_hrv [NI], e_hf [NI];
  logic [AW-1:0] e_addr [NI];
  logic [DW-1:0] e_wd [NI], e_drd [NI], e_hrd [NI];
  logic          rv [NI][16], rh [NI][16];
  logic [DW-1:0] rd [NI][16];

  logic          s_dg [NI], s_hr [NI], s_hf [NI], s_drv [NI], s_hrv [NI];
  logic [DW-1:0] s_hrd [NI];

  int log_cyc [$];
  int log_dat [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic d; logic [AW-1:0] da; logic h; logic we; logic [AW-1:0] ha; logic [DW-1:0] wd;
    logic x_dg; logic x_hr; logic x_hf; logic x_hrv; logic [DW-1:0] x_hrd;
  } vec_t;
  vec_t tbl [21];

  function automatic vec_t mk(input logic d, input logic [AW-1:0] da, input logic h,
                              input logic we, input logic [AW-1:0] ha, input logic [DW-1:0] wd,
                              input logic xdg, input logic xhr, input logic xhf,
                              input logic xhrv, input logic [DW-1:0] xhrd);
    vec_t v;
    v.d = d; v.da = da; v.h = h; v.we = we; v.ha = ha; v.wd = wd;
    v.x_dg = xdg; v.x_hr = xhr; v.x_hf = xhf; v.x_hrv = xhrv; v.x_hrd = xhrd;
    return v;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", nm, g, cyc, got, exp);
    end
  endtask

  task automatic model_clear(input int g);
    mwait[g] = 0; e_en[g] = 0; e_we[g] = 0; e_addr[g] = '0; e_wd[g] = '0;
    e_drv[g] = 0; e_hrv[g] = 0; e_drd[g] = '0; e_hrd[g] = '0; e_hf[g] = 0;
    for (int k = 0; k < 16; k++) begin rv[g][k] = 0; rh[g][k] = 0; rd[g][k] = '0; end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then step past the rising edge.
  task automatic step();
    int lat, sm, slot;
    logic frc, edg, ehr;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      lat = lat_of(g);
      sm  = sm_of(g);
      frc = rst_n && hv && (sm != 0) && (mwait[g] == sm);
      edg = rst_n && !frc && dreq;
      ehr = rst_n && (frc || (!dreq && hv));
      s_dg[g] = dg[g]; s_hr[g] = hr[g]; s_hf[g] = hf[g];
      s_drv[g] = drv[g]; s_hrv[g] = hrv[g]; s_hrd[g] = hrd[g];
      chk("disp_gnt",    g, 32'(dg[g]),  32'(edg));
      chk("host_ready",  g, 32'(hr[g]),  32'(ehr));
      chk("mem_en",      g, 32'(men[g]), 32'(e_en[g]));
      chk("mem_we",      g, 32'(mwe[g]), 32'(e_we[g]));
      chk("mem_addr",    g, 32'(mad[g]), 32'(e_addr[g]));
      chk("mem_wdata",   g, 32'(mwd[g]), 32'(e_wd[g]));
      chk("disp_rvalid", g, 32'(drv[g]), 32'(e_drv[g]));
      chk("host_rvalid", g, 32'(hrv[g]), 32'(e_hrv[g]));
      chk("disp_rdata",  g, 32'(drd[g]), 32'(e_drd[g]));
      chk("host_rdata",  g, 32'(hrd[g]), 32'(e_hrd[g]));
      chk("host_forced", g, 32'(hf[g]),  32'(e_hf[g]));
      if (!rst_n) begin
        model_clear(g);
      end else begin
        e_hf[g] = frc;
        mwait[g] = (!hv || ehr) ? 0 : ((mwait[g] == sm) ? sm : mwait[g] + 1);
        e_en[g] = edg || ehr;
        e_we[g] = ehr && hwe;
        if (edg) e_addr[g] = daddr;
        else if (ehr) e_addr[g] = haddr;
        if (ehr && hwe) begin
          e_wd[g] = hwdata;
          mm[g][haddr] = hwdata ^ haddr[DW-1:0];
        end
        if (e_en[g] && !e_we[g]) begin
          slot = (cyc + lat + 2) % 16;
          rv[g][slot] = 1;
          rh[g][slot] = ehr;
          rd[g][slot] = mm[g][e_addr[g]] ^ e_addr[g][DW-1:0];
        end
        slot = (cyc + 1) % 16;
        e_drv[g] = rv[g][slot] && !rh[g][slot];
        e_hrv[g] = rv[g][slot] && rh[g][slot];
        if (e_drv[g]) e_drd[g] = rd[g][slot];
        if (e_hrv[g]) e_hrd[g] = rd[g][slot];
        rv[g][slot] = 0;
      end
    end
    if (drv[0] === 1'b1) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(int'(drd[0]));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int c0;
    int nd [NI];
    logic [AW-1:0] tmp;

    rst_n = 0; dreq = 0; hv = 0; hwe = 0; daddr = '0; haddr = '0; hwdata = '0;
    for (int g = 0; g < NI; g++) model_clear(g);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with requests asserted: grants must stay low.
    dreq = 1; hv = 1;
    step();
    chk("rst_gnt_low", 0, 32'(s_dg[0]), 32'd0);
    rst_n = 1; dreq = 0; hv = 0;
    step();

    // Reset mid-operation: display read of 0x00010 dropped.
    dreq = 1; daddr = AW'(17'h00010);
    step();
    chk("rst_accept", 0, 32'(s_dg[0]), 32'd1);
    rst_n = 0; dreq = 0;
    step();
    rst_n = 1;
    for (int g = 0; g < NI; g++) nd[g] = 0;
    repeat (8) begin
      step();
      for (int g = 0; g < NI; g++) nd[g] += int'(s_drv[g]);
    end
    for (int g = 0; g < NI; g++) chk("rst_drop", g, 32'(nd[g]), 32'd0);

    // Display-only stream, addresses 0..9.
    log_cyc.delete(); log_dat.delete();
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      dreq = 1; daddr = AW'(i);
      step();
      chk("stream_gnt", 0, 32'(s_dg[0]), 32'd1);
    end
    dreq = 0;
    repeat (8) step();
    chk("stream_n", 0, 32'(log_cyc.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_cyc.size(); i++) begin
      chk("stream_lat", 0, 32'(log_cyc[i] - c0), 32'(4 + i));
      chk("stream_dat", 0, 32'(log_dat[i]), 32'(i));
    end

    // Vector table: host write/read without contention, then starvation forcing.
    tbl[0] = mk(0, '0, 1, 1, AW'(5), 12'hABC, 0, 1, 0, 0, '0);
    tbl[1] = mk(0, '0, 1, 0, AW'(5), '0,      0, 1, 0, 0, '0);
    for (int k = 2; k < 5; k++) tbl[k] = mk(0, '0, 0, 0, '0, '0, 0, 0, 0, 0, '0);
    tbl[5] = mk(0, '0, 0, 0, '0, '0, 0, 0, 0, 1, 12'hABC);
    for (int k = 0; k < 8; k++) tbl[6+k] = mk(1, AW'(32 + k), 1, 0, AW'(7), '0, 1, 0, 0, 0, '0);
    tbl[14] = mk(1, AW'(40), 1, 0, AW'(7), '0, 0, 1, 0, 0, '0);
    tbl[15] = mk(1, AW'(40), 0, 0, '0, '0, 1, 0, 1, 0, '0);
    for (int k = 16; k < 21; k++) tbl[k] = mk(0, '0, 0, 0, '0, '0, 0, 0, 0, 0, '0);
    tbl[18].x_hrv = 1; tbl[18].x_hrd = 12'h007;
    for (int i = 0; i < 21; i++) begin
      dreq = tbl[i].d; daddr = tbl[i].da; hv = tbl[i].h; hwe = tbl[i].we;
      haddr = tbl[i].ha; hwdata = tbl[i].wd;
      step();
      chk("tbl_dg",  i, 32'(s_dg[0]),  32'(tbl[i].x_dg));
      chk("tbl_hr",  i, 32'(s_hr[0]),  32'(tbl[i].x_hr));
      chk("tbl_hf",  i, 32'(s_hf[0]),  32'(tbl[i].x_hf));
      chk("tbl_hrv", i, 32'(s_hrv[0]), 32'(tbl[i].x_hrv));
      if (tbl[i].x_hrv) chk("tbl_hrd", i, 32'(s_hrd[0]), 32'(tbl[i].x_hrd));
    end

    // Forcing disabled (instance 2): host waits as long as display requests.
    for (int i = 0; i < 50; i++) begin
      dreq = 1; daddr = AW'($urandom_range(0, 63)); hv = 1; hwe = 0; haddr = AW'(9);
      step();
      chk("nofrc_hr", 2, 32'(s_hr[2]), 32'd0);
    end
    dreq = 0;
    step();
    chk("nofrc_acc", 2, 32'(s_hr[2]), 32'd1);
    hv = 0;
    step();

    // Interleaved owners (instance 1, limit 1, latency 3): alternate display / forced host.
    haddr = AW'(2 * $urandom_range(0, 200) + 1);
    for (int i = 0; i < 20; i++) begin
      dreq = 1; daddr = AW'(2 * $urandom_range(0, 200)); hv = 1; hwe = 0;
      step();
      chk("alt_gnt", 1, 32'(s_dg[1]), 32'((i % 2) == 0));
      chk("alt_both", 1, 32'(s_drv[1] && s_hrv[1]), 32'd0);
      if (s_hr[1]) haddr = AW'(2 * $urandom_range(0, 200) + 1);
    end
    dreq = 0; hv = 0;
    repeat (8) begin
      step();
      chk("alt_both", 1, 32'(s_drv[1] && s_hrv[1]), 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      dreq  = ($urandom_range(0, 2) != 0);
      hv    = $urandom_range(0, 1) != 0;
      hwe   = $urandom_range(0, 1) != 0;
      tmp   = AW'($urandom);
      daddr = ($urandom_range(0, 7) == 0) ? tmp : AW'($urandom_range(0, 31));
      haddr = AW'($urandom_range(0, 31));
      hwdata = DW'($urandom);
      step();
    end
    rst_n = 1; dreq = 0; hv = 0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port framebuffer arbiter between the VGA display fetch path and a host (pattern generator / control logic) read-write port. One memory access per cycle. Display has priority, with a bounded-wait guarantee for the host. Read data returns through a fixed-latency pipeline and is routed back to the requester that issued the read. Sits in top between the VGA timing/pixel path and the framebuffer RAM.

Parameters:
ADDR_W, 17, framebuffer word address width
DATA_W, 12, pixel word width (4b R, 4b G, 4b B)
MEM_LAT, 2, RAM read latency in cycles from registered mem_en to mem_rdata valid (1..4)
STARVE_MAX, 8, consecutive host-wait cycles before the host is forced a grant; 0 disables forcing

Ports:
Clock  in  1  system clock (CLK_50 domain)
Reset  in  1  synchronous, active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle (combinational)
disp_rdata  out  DATA_W  display read data
disp_rvalid  out  1  disp_rdata valid
host_valid  in  1  host request
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ready  out  1  host request accepted this cycle (combinational)
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  host_rdata valid
host_forced  out  1  registered; pulses 1 cycle after a starvation-forced host grant
mem_en  out  1  RAM access enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (Reset=0 at a Clock edge): mem_en, mem_we, disp_rvalid, host_rvalid, host_forced = 0; mem_addr, mem_wdata, disp_rdata, host_rdata = 0; wait_cnt = 0; return pipeline cleared. In-flight reads are dropped: no rvalid for any read issued before reset. disp_gnt and host_ready are forced to 0 while Reset=0.
- Grant (combinational, at most one per cycle):
  - force = host_valid && STARVE_MAX!=0 && wait_cnt==STARVE_MAX.
  - force: host_ready=1, disp_gnt=0.
  - else if disp_req: disp_gnt=1, host_ready=0.
  - else: host_ready=host_valid.
- A handshake completes on req&gnt / valid&ready. Requesters hold request and fields stable until accepted.
- wait_cnt (saturating at STARVE_MAX):
  - set to 0 when host_valid=0 or host_ready=1;
  - incremented when host_valid=1 and host_ready=0.
- Issue, 1 cycle after accept:
  - mem_en=1, mem_addr = the accepted address.
  - mem_we = host_we for host, 0 for display; mem_wdata = host_wdata on a host write.
  - With no accept: mem_en=0, mem_we=0, addr/wdata hold.
- Return pipeline: MEM_LAT-deep shift of {valid, owner}, loaded when a read issues (mem_en && !mem_we).
  - At the tail, mem_rdata is registered into the owner's rdata, and that owner's rvalid pulses for 1 cycle.
  - Total latency from accept to rvalid = MEM_LAT+2 cycles.
  - Back-to-back reads return in order, one per cycle.
  - Writes generate no rvalid.
- Registered host_forced = 1 in the cycle after a forced grant.
- A display request denied by a force is served next cycle (wait_cnt=0 then).
- Host write followed immediately by a host read of the same address: the read issues the cycle after the write, and the RAM returns the written data.
- rdata registers hold their last value when rvalid=0.

Test Plan:
- Reset mid-operation: display read of addr 0x00010 accepted; Reset=0 for 1 cycle, 1 cycle later -> all outputs 0; no disp_rvalid ever appears for 0x00010.
- Display-only stream: disp_req=1 for 10 cycles, addr 0..9, RAM model returns data=addr, MEM_LAT=2 -> disp_gnt=1 every cycle; disp_rvalid contiguous for 10 cycles starting 4 cycles after the first accept, data 0..9 in order.
- Host idle contention: disp_req=0, host write 0x0ABC to addr 5, then host read addr 5 -> host_ready=1 both cycles; mem_we=1 then 0; host_rvalid with 0x0ABC, 4 cycles after the read accept.
- Starvation, STARVE_MAX=8: disp_req held 1, host_valid=1 (read addr 7) -> 8 display grants, then host_ready=1 on the 9th cycle; host_forced=1 the next cycle; disp_gnt resumes the cycle after.
- Forcing disabled, STARVE_MAX=0: disp_req held 1 for 50 cycles with host_valid=1 -> host_ready stays 0 throughout; host accepted the first cycle disp_req=0.
- Interleaved owners: alternate forced host read / display read with MEM_LAT=3 -> every rvalid routed to the correct owner; no cycle with both rvalids set.
